// File: rtl/stack_ctrl_param_pkg.sv
// Shared definitions for the parametrised LIFO stack controller:
// default geometry, pointer-width derivation and stack operation decode.
package stack_ctrl_param_pkg;

    localparam int DEF_DATA_WIDTH = 8;
    localparam int DEF_DEPTH      = 8;

    typedef enum logic [1:0] {
        OP_NONE = 2'd0,
        OP_PUSH = 2'd1,
        OP_POP  = 2'd2,
        OP_REPL = 2'd3
    } stack_op_e;

    // Occupancy runs 0..DEPTH inclusive, so it needs one more code than the address.
    function automatic int ptr_width(input int depth);
        return $clog2(depth + 1);
    endfunction

    function automatic int addr_width(input int depth);
        return (depth > 1) ? $clog2(depth) : 1;
    endfunction

    // Flush masks everything. A push+pop on an empty stack degrades to a plain
    // push, and a push+pop on a full stack is a replace, never an overflow.
    function automatic stack_op_e decode_op(
        input logic flush,
        input logic push,
        input logic pop,
        input logic full,
        input logic empty
    );
        stack_op_e op;
        op = OP_NONE;
        if (flush) begin
            op = OP_NONE;
        end else if (push && pop && !empty) begin
            op = OP_REPL;
        end else if (push && !full) begin
            op = OP_PUSH;
        end else if (pop && !push && !empty) begin
            op = OP_POP;
        end
        return op;
    endfunction

endpackage

// File: rtl/stack_ctrl_param_ram.sv
// Simple dual-port stack RAM: synchronous write port, registered read port.
// Read-first on address collision; read data holds while no read is issued.
module stack_ctrl_param_ram #(
    parameter int DATA_WIDTH = 8,
    parameter int DEPTH      = 8,
    parameter int ADDR_W     = 3
) (
    input  logic                  i_clk,
    input  logic                  i_rst_n,
    input  logic                  i_we,
    input  logic [ADDR_W-1:0]     i_waddr,
    input  logic [DATA_WIDTH-1:0] i_wdata,
    input  logic                  i_re,
    input  logic [ADDR_W-1:0]     i_raddr,
    output logic [DATA_WIDTH-1:0] o_rdata
);

    logic [DATA_WIDTH-1:0] r_mem [DEPTH];
    logic [DATA_WIDTH-1:0] r_rdata;

    // Storage is deliberately left out of reset.
    always_ff @(posedge i_clk) begin
        if (i_we) begin
            r_mem[i_waddr] <= i_wdata;
        end
    end

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_rdata <= '0;
        end else if (i_re) begin
            r_rdata <= r_mem[i_raddr];
        end
    end

    assign o_rdata = r_rdata;

endmodule

// File: rtl/stack_ctrl_param.sv
// Parametrised LIFO stack controller: push, pop, replace-top, flush, sticky errors.
// Pop data is registered (one clock to dout_valid); status flags decode sp directly.
module stack_ctrl_param
    import stack_ctrl_param_pkg::*;
#(
    parameter int DATA_WIDTH = DEF_DATA_WIDTH,
    parameter int DEPTH      = DEF_DEPTH,
    parameter int AF_LEVEL   = DEPTH - 1,
    parameter int PTR_W      = ptr_width(DEPTH)
) (
    input  logic                  i_clk,
    input  logic                  i_rst_n,
    input  logic [DATA_WIDTH-1:0] i_din,
    input  logic                  i_push,
    input  logic                  i_pop,
    input  logic                  i_flush,
    input  logic                  i_clr_err,
    output logic [DATA_WIDTH-1:0] o_dout,
    output logic                  o_dout_valid,
    output logic                  o_push_ack,
    output logic                  o_pop_ack,
    output logic                  o_full,
    output logic                  o_empty,
    output logic                  o_almost_full,
    output logic [PTR_W-1:0]      o_count,
    output logic                  o_overflow,
    output logic                  o_underflow
);

    localparam int               ADDR_W  = addr_width(DEPTH);
    localparam logic [PTR_W-1:0] SP_FULL = PTR_W'(DEPTH);
    localparam logic [PTR_W-1:0] AF_THR  = PTR_W'(AF_LEVEL);
    localparam logic [PTR_W-1:0] SP_ONE  = PTR_W'(1);

    logic [PTR_W-1:0]      r_sp;
    logic                  r_dout_vld;
    logic                  r_push_ack;
    logic                  r_pop_ack;
    logic                  r_overflow;
    logic                  r_underflow;

    logic                  w_full;
    logic                  w_empty;
    stack_op_e             w_op;
    logic                  w_ovf_evt;
    logic                  w_udf_evt;
    logic                  w_we;
    logic                  w_re;
    logic [ADDR_W-1:0]     w_top_addr;
    logic [ADDR_W-1:0]     w_push_addr;
    logic [ADDR_W-1:0]     w_waddr;
    logic [DATA_WIDTH-1:0] w_rdata;

    assign w_full  = (r_sp == SP_FULL);
    assign w_empty = (r_sp == '0);

    assign w_op = decode_op(i_flush, i_push, i_pop, w_full, w_empty);

    // Replace on a full stack is legal, so only a lone push can overflow.
    assign w_ovf_evt = !i_flush && i_push && !i_pop && w_full;
    assign w_udf_evt = !i_flush && i_pop && w_empty;

    assign w_top_addr  = ADDR_W'(r_sp - SP_ONE);
    assign w_push_addr = ADDR_W'(r_sp);

    assign w_we    = (w_op == OP_PUSH) || (w_op == OP_REPL);
    assign w_re    = (w_op == OP_POP)  || (w_op == OP_REPL);
    assign w_waddr = (w_op == OP_PUSH) ? w_push_addr : w_top_addr;

    stack_ctrl_param_ram #(
        .DATA_WIDTH (DATA_WIDTH),
        .DEPTH      (DEPTH),
        .ADDR_W     (ADDR_W)
    ) u_ram (
        .i_clk   (i_clk),
        .i_rst_n (i_rst_n),
        .i_we    (w_we),
        .i_waddr (w_waddr),
        .i_wdata (i_din),
        .i_re    (w_re),
        .i_raddr (w_top_addr),
        .o_rdata (w_rdata)
    );

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_sp <= '0;
        end else if (i_flush) begin
            r_sp <= '0;
        end else begin
            case (w_op)
                OP_PUSH: r_sp <= r_sp + SP_ONE;
                OP_POP:  r_sp <= r_sp - SP_ONE;
                default: r_sp <= r_sp;
            endcase
        end
    end

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_dout_vld <= 1'b0;
            r_push_ack <= 1'b0;
            r_pop_ack  <= 1'b0;
        end else begin
            r_dout_vld <= w_re;
            r_push_ack <= w_we;
            r_pop_ack  <= w_re;
        end
    end

    // A fresh error in the clearing cycle keeps the flag set.
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_overflow  <= 1'b0;
            r_underflow <= 1'b0;
        end else begin
            r_overflow  <= w_ovf_evt || (r_overflow  && !i_clr_err);
            r_underflow <= w_udf_evt || (r_underflow && !i_clr_err);
        end
    end

    assign o_dout        = w_rdata;
    assign o_dout_valid  = r_dout_vld;
    assign o_push_ack    = r_push_ack;
    assign o_pop_ack     = r_pop_ack;
    assign o_full        = w_full;
    assign o_empty       = w_empty;
    assign o_almost_full = (r_sp >= AF_THR);
    assign o_count       = r_sp;
    assign o_overflow    = r_overflow;
    assign o_underflow   = r_underflow;

endmodule

// File: tb/tb_stack_ctrl_param.sv
// Directed bench for stack_ctrl_param: three 4-deep instances sharing stimulus,
// differing only in almost-full threshold (3, 1, 0).
module tb_stack_ctrl_param;

    localparam int DW = 8;
    localparam int DP = 4;
    localparam int PW = 3;
    localparam int NI = 3;

    typedef struct packed {
        logic [DW-1:0] dout;
        logic          dv;
        logic          pa;
        logic          pk;
        logic          full;
        logic          empty;
        logic          af;
        logic [PW-1:0] cnt;
        logic          ovf;
        logic          udf;
    } obs_t;

    typedef struct {
        logic          push;
        logic          pop;
        logic          flush;
        logic          clr;
        logic [DW-1:0] din;
        logic [DW-1:0] e_dout;
        logic          e_dv;
        logic          e_pa;
        logic          e_pk;
        logic [PW-1:0] e_cnt;
        logic          e_ovf;
        logic          e_udf;
    } vec_t;

    int thr [NI] = '{3, 1, 0};

    logic          clk;
    logic          rst_n;
    logic [DW-1:0] din;
    logic          push, pop, flush, clr_err;

    logic [DW-1:0] w_dout [NI];
    logic          w_dv [NI], w_pa [NI], w_pk [NI], w_full [NI], w_empty [NI];
    logic          w_af [NI], w_ovf [NI], w_udf [NI];
    logic [PW-1:0] w_cnt [NI];

    int n_vec = 0;
    int n_err = 0;
    vec_t vq[$];

    initial clk = 1'b0;
    always #5 clk = ~clk;

    stack_ctrl_param #(.DATA_WIDTH(DW), .DEPTH(DP), .AF_LEVEL(3)) u_dut (
        .i_clk(clk), .i_rst_n(rst_n), .i_din(din), .i_push(push), .i_pop(pop),
        .i_flush(flush), .i_clr_err(clr_err), .o_dout(w_dout[0]), .o_dout_valid(w_dv[0]),
        .o_push_ack(w_pa[0]), .o_pop_ack(w_pk[0]), .o_full(w_full[0]), .o_empty(w_empty[0]),
        .o_almost_full(w_af[0]), .o_count(w_cnt[0]), .o_overflow(w_ovf[0]), .o_underflow(w_udf[0])
    );

    stack_ctrl_param #(.DATA_WIDTH(DW), .DEPTH(DP), .AF_LEVEL(1)) u_af1 (
        .i_clk(clk), .i_rst_n(rst_n), .i_din(din), .i_push(push), .i_pop(pop),
        .i_flush(flush), .i_clr_err(clr_err), .o_dout(w_dout[1]), .o_dout_valid(w_dv[1]),
        .o_push_ack(w_pa[1]), .o_pop_ack(w_pk[1]), .o_full(w_full[1]), .o_empty(w_empty[1]),
        .o_almost_full(w_af[1]), .o_count(w_cnt[1]), .o_overflow(w_ovf[1]), .o_underflow(w_udf[1])
    );

    stack_ctrl_param #(.DATA_WIDTH(DW), .DEPTH(DP), .AF_LEVEL(0)) u_af0 (
        .i_clk(clk), .i_rst_n(rst_n), .i_din(din), .i_push(push), .i_pop(pop),
        .i_flush(flush), .i_clr_err(clr_err), .o_dout(w_dout[2]), .o_dout_valid(w_dv[2]),
        .o_push_ack(w_pa[2]), .o_pop_ack(w_pk[2]), .o_full(w_full[2]), .o_empty(w_empty[2]),
        .o_almost_full(w_af[2]), .o_count(w_cnt[2]), .o_overflow(w_ovf[2]), .o_underflow(w_udf[2])
    );

    function automatic obs_t get_obs(input int k);
        obs_t o;
        o.dout = w_dout[k]; o.dv = w_dv[k]; o.pa = w_pa[k]; o.pk = w_pk[k];
        o.full = w_full[k]; o.empty = w_empty[k]; o.af = w_af[k];
        o.cnt = w_cnt[k]; o.ovf = w_ovf[k]; o.udf = w_udf[k];
        return o;
    endfunction

    // Status flags follow from the expected occupancy and the instance threshold.
    function automatic obs_t exp_obs(input logic [DW-1:0] d, input logic dv, pa, pk,
                                     input logic [PW-1:0] cnt, input logic ovf, udf,
                                     input int t);
        obs_t o;
        o.dout = d; o.dv = dv; o.pa = pa; o.pk = pk;
        o.full = (int'(cnt) == DP); o.empty = (cnt == '0); o.af = (int'(cnt) >= t);
        o.cnt = cnt; o.ovf = ovf; o.udf = udf;
        return o;
    endfunction

    function automatic vec_t v(input logic pu, po, fl, cl, input logic [DW-1:0] d,
                               input logic [DW-1:0] ed, input logic edv, epa, epk,
                               input logic [PW-1:0] ec, input logic eo, eu);
        vec_t r;
        r.push = pu; r.pop = po; r.flush = fl; r.clr = cl; r.din = d;
        r.e_dout = ed; r.e_dv = edv; r.e_pa = epa; r.e_pk = epk;
        r.e_cnt = ec; r.e_ovf = eo; r.e_udf = eu;
        return r;
    endfunction

    task automatic check_all(input string name, input logic [DW-1:0] d, input logic dv, pa, pk,
                             input logic [PW-1:0] cnt, input logic ovf, udf);
        obs_t a, e;
        for (int k = 0; k < NI; k++) begin
            a = get_obs(k);
            e = exp_obs(d, dv, pa, pk, cnt, ovf, udf, thr[k]);
            n_vec++;
            if (a !== e) begin
                n_err++;
                $display("FAIL %s af%0d: got dout=%h dv=%b pa=%b pk=%b full=%b empty=%b af=%b cnt=%0d ovf=%b udf=%b, want dout=%h dv=%b pa=%b pk=%b full=%b empty=%b af=%b cnt=%0d ovf=%b udf=%b",
                         name, thr[k], a.dout, a.dv, a.pa, a.pk, a.full, a.empty, a.af, a.cnt, a.ovf, a.udf,
                         e.dout, e.dv, e.pa, e.pk, e.full, e.empty, e.af, e.cnt, e.ovf, e.udf);
            end
        end
    endtask

    task automatic drive(input logic pu, po, fl, cl, input logic [DW-1:0] d);
        push = pu; pop = po; flush = fl; clr_err = cl; din = d;
    endtask

    initial begin
        rst_n = 1'b0;
        drive(0, 0, 0, 0, 8'h00);

        //           push pop fl clr din    | dout  dv pa pk cnt ovf udf
        vq.push_back(v(1, 0, 0, 0, 8'h11,  8'h00, 0, 1, 0, 3'd1, 0, 0));
        vq.push_back(v(1, 0, 0, 0, 8'h22,  8'h00, 0, 1, 0, 3'd2, 0, 0));
        vq.push_back(v(1, 0, 0, 0, 8'h33,  8'h00, 0, 1, 0, 3'd3, 0, 0));
        vq.push_back(v(0, 1, 0, 0, 8'h00,  8'h33, 1, 0, 1, 3'd2, 0, 0));
        vq.push_back(v(0, 1, 0, 0, 8'h00,  8'h22, 1, 0, 1, 3'd1, 0, 0));
        vq.push_back(v(0, 1, 0, 0, 8'h00,  8'h11, 1, 0, 1, 3'd0, 0, 0));
        vq.push_back(v(0, 1, 0, 0, 8'h00,  8'h11, 0, 0, 0, 3'd0, 0, 1));
        vq.push_back(v(0, 0, 0, 0, 8'h00,  8'h11, 0, 0, 0, 3'd0, 0, 1));
        vq.push_back(v(0, 0, 0, 1, 8'h00,  8'h11, 0, 0, 0, 3'd0, 0, 0));
        vq.push_back(v(1, 0, 0, 0, 8'hA1,  8'h11, 0, 1, 0, 3'd1, 0, 0));
        vq.push_back(v(1, 0, 0, 0, 8'hA2,  8'h11, 0, 1, 0, 3'd2, 0, 0));
        vq.push_back(v(1, 0, 0, 0, 8'hA3,  8'h11, 0, 1, 0, 3'd3, 0, 0));
        vq.push_back(v(1, 0, 0, 0, 8'hA4,  8'h11, 0, 1, 0, 3'd4, 0, 0));
        vq.push_back(v(1, 0, 0, 0, 8'hAA,  8'h11, 0, 0, 0, 3'd4, 1, 0));
        vq.push_back(v(0, 1, 0, 0, 8'h00,  8'hA4, 1, 0, 1, 3'd3, 1, 0));
        vq.push_back(v(0, 0, 0, 1, 8'h00,  8'hA4, 0, 0, 0, 3'd3, 0, 0));
        vq.push_back(v(1, 1, 0, 0, 8'h44,  8'hA3, 1, 1, 1, 3'd3, 0, 0));
        vq.push_back(v(0, 1, 0, 0, 8'h00,  8'h44, 1, 0, 1, 3'd2, 0, 0));
        vq.push_back(v(1, 0, 0, 0, 8'h55,  8'h44, 0, 1, 0, 3'd3, 0, 0));
        vq.push_back(v(1, 0, 0, 0, 8'h66,  8'h44, 0, 1, 0, 3'd4, 0, 0));
        vq.push_back(v(1, 1, 0, 0, 8'h77,  8'h66, 1, 1, 1, 3'd4, 0, 0));
        vq.push_back(v(0, 1, 0, 0, 8'h00,  8'h77, 1, 0, 1, 3'd3, 0, 0));
        vq.push_back(v(1, 0, 1, 0, 8'h99,  8'h77, 0, 0, 0, 3'd0, 0, 0));
        vq.push_back(v(0, 1, 0, 0, 8'h00,  8'h77, 0, 0, 0, 3'd0, 0, 1));
        vq.push_back(v(0, 0, 0, 1, 8'h00,  8'h77, 0, 0, 0, 3'd0, 0, 0));
        vq.push_back(v(1, 1, 0, 0, 8'h12,  8'h77, 0, 1, 0, 3'd1, 0, 1));
        vq.push_back(v(0, 1, 0, 1, 8'h00,  8'h12, 1, 0, 1, 3'd0, 0, 0));
        vq.push_back(v(0, 1, 0, 1, 8'h00,  8'h12, 0, 0, 0, 3'd0, 0, 1));
        vq.push_back(v(0, 1, 1, 0, 8'h00,  8'h12, 0, 0, 0, 3'd0, 0, 1));

        #1;
        check_all("reset", 8'h00, 0, 0, 0, 3'd0, 0, 0);
        @(negedge clk);
        rst_n = 1'b1;

        foreach (vq[i]) begin
            @(negedge clk);
            drive(vq[i].push, vq[i].pop, vq[i].flush, vq[i].clr, vq[i].din);
            @(posedge clk);
            #1;
            check_all($sformatf("vec%0d", i), vq[i].e_dout, vq[i].e_dv, vq[i].e_pa,
                      vq[i].e_pk, vq[i].e_cnt, vq[i].e_ovf, vq[i].e_udf);
        end

        // Reset asserted between edges while a pop result is being presented.
        @(negedge clk); drive(1, 0, 0, 0, 8'h5A);
        @(posedge clk); #1;
        check_all("pre_rst_push1", 8'h12, 0, 1, 0, 3'd1, 0, 1);
        @(negedge clk); drive(1, 0, 0, 0, 8'h5B);
        @(posedge clk); #1;
        check_all("pre_rst_push2", 8'h12, 0, 1, 0, 3'd2, 0, 1);
        @(negedge clk); drive(0, 1, 0, 0, 8'h00);
        @(posedge clk); #1;
        check_all("pre_rst_pop", 8'h5B, 1, 0, 1, 3'd1, 0, 1);
        #2 rst_n = 1'b0;
        #1;
        check_all("async_rst", 8'h00, 0, 0, 0, 3'd0, 0, 0);
        @(posedge clk); #1;
        check_all("held_rst_pop", 8'h00, 0, 0, 0, 3'd0, 0, 0);
        @(negedge clk); rst_n = 1'b1;
        @(posedge clk); #1;
        check_all("post_rst_pop", 8'h00, 0, 0, 0, 3'd0, 0, 1);

        @(negedge clk); drive(0, 0, 0, 0, 8'h00);
        @(negedge clk);
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
